// File: rtl/reg_decoder_pkg.sv
// Shared definitions for the decode/operand stage: widths, instruction field positions,
// immediate-extension opcodes and architectural register indices.
package reg_decoder_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_NUM = 32;
    localparam int REG_AW  = 5;

    localparam logic [DATA_W-1:0] SP_INIT_DEFAULT = 32'h0000_7FFC;

    localparam int REG_SP = 29;
    localparam int REG_RA = 31;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

    // Logical immediates and sltiu treat imm as unsigned; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] opcode);
        return (opcode == OPC_ANDI) || (opcode == OPC_ORI) ||
               (opcode == OPC_XORI) || (opcode == OPC_SLTIU);
    endfunction

endpackage

// File: rtl/reg_decoder_if.sv
// Decode-stage bus: fetch/ALU/memory inputs toward the decoder and operand outputs toward the ALU.
// master drives instruction and write-back inputs; slave is the decoder itself.
interface reg_decoder_if;
    import reg_decoder_pkg::*;

    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] opcplus4;
    logic              reg_write;
    logic              reg_dst;
    logic              memto_reg;
    logic              jal;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] imme_extend;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instruction, alu_result, mem_data, opcplus4,
        output reg_write, reg_dst, memto_reg, jal, dbg_addr,
        input  read_data_1, read_data_2, imme_extend, dbg_data
    );

    modport slave (
        input  instruction, alu_result, mem_data, opcplus4,
        input  reg_write, reg_dst, memto_reg, jal, dbg_addr,
        output read_data_1, read_data_2, imme_extend, dbg_data
    );

endinterface

// File: rtl/reg_decoder_gpr_file.sv
// 31 x 32-bit general register file, $0 hardwired to zero, $29 resets to SP_INIT.
// Latency: reads combinational (old value during a write), write lands on the rising edge; no backpressure.
module reg_decoder_gpr_file
    import reg_decoder_pkg::*;
#(
    parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_addr_1,
    input  logic [REG_AW-1:0] rd_addr_2,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [1:REG_NUM-1];
    logic [DATA_W-1:0] regs_d [1:REG_NUM-1];

    // No storage for $0: a write addressed to it never matches any entry.
    always_comb begin
        for (int i = 1; i < REG_NUM; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_addr == REG_AW'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= (i == REG_SP) ? SP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data_1 = '0;
        rd_data_2 = '0;
        dbg_data  = '0;
        if (rd_addr_1 != '0) rd_data_1 = regs_q[rd_addr_1];
        if (rd_addr_2 != '0) rd_data_2 = regs_q[rd_addr_2];
        if (dbg_addr  != '0) dbg_data  = regs_q[dbg_addr];
    end

endmodule

// File: rtl/reg_decoder.sv
// Decode/operand stage: field split, immediate extension, write-back muxing around the GPR file.
// Latency: operands and immediate are combinational, write-back commits on the rising edge; no backpressure.
module reg_decoder
    import reg_decoder_pkg::*;
#(
    parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    reg_decoder_if.slave  bus
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        opcode = bus.instruction[OPC_MSB:OPC_LSB];
        rs     = bus.instruction[RS_MSB:RS_LSB];
        rt     = bus.instruction[RT_MSB:RT_LSB];
        rd     = bus.instruction[RD_MSB:RD_LSB];
        imm    = bus.instruction[IMM_MSB:IMM_LSB];
    end

    always_comb begin
        bus.imme_extend = is_zero_ext(opcode) ? {{(DATA_W-16){1'b0}}, imm}
                                              : {{(DATA_W-16){imm[15]}}, imm};
    end

    // jal alone is enough to commit the link, whatever reg_write/reg_dst/memto_reg say.
    always_comb begin
        wr_en   = bus.reg_write | bus.jal;
        wr_addr = bus.jal ? REG_AW'(REG_RA) : (bus.reg_dst ? rd : rt);
        wr_data = bus.jal ? bus.opcplus4 : (bus.memto_reg ? bus.mem_data : bus.alu_result);
    end

    reg_decoder_gpr_file #(
        .SP_INIT (SP_INIT)
    ) u_gpr_file (
        .clock     (clock),
        .reset     (reset),
        .rd_addr_1 (rs),
        .rd_addr_2 (rt),
        .dbg_addr  (bus.dbg_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data_1 (bus.read_data_1),
        .rd_data_2 (bus.read_data_2),
        .dbg_data  (bus.dbg_data)
    );

endmodule

// File: tb/tb_reg_decoder.sv
// Directed bench for reg_decoder: reset values, write-back muxing, $0, jal, immediate extension.
module tb_reg_decoder;
    import reg_decoder_pkg::*;

    localparam logic [31:0] SP_EXP = 32'h0000_7FFC;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

    reg_decoder_if dif ();

    reg_decoder #(.SP_INIT(SP_EXP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic idle_inputs();
        dif.instruction = 32'h0;
        dif.alu_result  = 32'h0;
        dif.mem_data    = 32'h0;
        dif.opcplus4    = 32'h0;
        dif.reg_write   = 1'b0;
        dif.reg_dst     = 1'b0;
        dif.memto_reg   = 1'b0;
        dif.jal         = 1'b0;
        dif.dbg_addr    = 5'd0;
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        dif.instruction = enc(6'h00, 5'd29, 5'd5, 16'h8001);
        dif.dbg_addr = 5'd29;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (dif.read_data_1 !== SP_EXP) $display("FAIL reset_rd1_sp: got %h want %h", dif.read_data_1, SP_EXP);
        else passed++;
        total++;
        if (dif.read_data_2 !== 32'h0) $display("FAIL reset_rd2_r5: got %h want %h", dif.read_data_2, 32'h0);
        else passed++;
        total++;
        if (dif.dbg_data !== SP_EXP) $display("FAIL reset_dbg_sp: got %h want %h", dif.dbg_data, SP_EXP);
        else passed++;
        total++;
        if (dif.imme_extend !== 32'hFFFF_8001) $display("FAIL reset_imm: got %h want %h", dif.imme_extend, 32'hFFFF_8001);
        else passed++;
    endtask

    task automatic test_write_rt();
        idle_inputs();
        dif.instruction = enc(6'h08, 5'd8, 5'd8, 16'h0000);
        dif.reg_write   = 1'b1;
        dif.reg_dst     = 1'b0;
        dif.alu_result  = 32'hDEAD_BEEF;
        dif.mem_data    = 32'h0BAD_0BAD;
        #1;
        total++;
        if (dif.read_data_2 !== 32'h0) $display("FAIL rt_old_value: got %h want %h", dif.read_data_2, 32'h0);
        else passed++;
        tick();
        dif.reg_write = 1'b0;
        #1;
        total++;
        if (dif.read_data_2 !== 32'hDEAD_BEEF) $display("FAIL rt_new_value: got %h want %h", dif.read_data_2, 32'hDEAD_BEEF);
        else passed++;
        total++;
        if (dif.read_data_1 !== 32'hDEAD_BEEF) $display("FAIL rs_new_value: got %h want %h", dif.read_data_1, 32'hDEAD_BEEF);
        else passed++;
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        // rd=0, rt=8: destination is $0, $8 must keep its value.
        dif.instruction = enc(6'h00, 5'd0, 5'd8, {5'd0, 11'h020});
        dif.reg_write   = 1'b1;
        dif.reg_dst     = 1'b1;
        dif.alu_result  = 32'h0000_1234;
        tick();
        dif.reg_write = 1'b0;
        dif.dbg_addr  = 5'd0;
        #1;
        total++;
        if (dif.read_data_1 !== 32'h0) $display("FAIL zero_rd1: got %h want %h", dif.read_data_1, 32'h0);
        else passed++;
        total++;
        if (dif.dbg_data !== 32'h0) $display("FAIL zero_dbg: got %h want %h", dif.dbg_data, 32'h0);
        else passed++;
        total++;
        if (dif.read_data_2 !== 32'hDEAD_BEEF) $display("FAIL zero_rt_untouched: got %h want %h", dif.read_data_2, 32'hDEAD_BEEF);
        else passed++;
    endtask

    task automatic test_rd_dest();
        idle_inputs();
        dif.instruction = enc(6'h00, 5'd12, 5'd8, {5'd12, 11'h020});
        dif.reg_write   = 1'b1;
        dif.reg_dst     = 1'b1;
        dif.alu_result  = 32'h0BAD_F00D;
        tick();
        dif.reg_write = 1'b0;
        #1;
        total++;
        if (dif.read_data_1 !== 32'h0BAD_F00D) $display("FAIL rd_dest_written: got %h want %h", dif.read_data_1, 32'h0BAD_F00D);
        else passed++;
        total++;
        if (dif.read_data_2 !== 32'hDEAD_BEEF) $display("FAIL rd_dest_rt_kept: got %h want %h", dif.read_data_2, 32'hDEAD_BEEF);
        else passed++;
    endtask

    task automatic test_jal();
        idle_inputs();
        // Conflicting controls must all be overridden by jal.
        dif.instruction = enc(6'h03, 5'd10, 5'd10, {5'd10, 11'h000});
        dif.jal         = 1'b1;
        dif.reg_write   = 1'b0;
        dif.reg_dst     = 1'b1;
        dif.memto_reg   = 1'b1;
        dif.opcplus4    = 32'h0040_0010;
        dif.mem_data    = 32'h7777_7777;
        dif.alu_result  = 32'h6666_6666;
        tick();
        dif.jal      = 1'b0;
        dif.dbg_addr = 5'd31;
        #1;
        total++;
        if (dif.dbg_data !== 32'h0040_0010) $display("FAIL jal_link: got %h want %h", dif.dbg_data, 32'h0040_0010);
        else passed++;
        total++;
        if (dif.read_data_1 !== 32'h0) $display("FAIL jal_rd_untouched: got %h want %h", dif.read_data_1, 32'h0);
        else passed++;
    endtask

    task automatic test_extend();
        logic [5:0]  ops  [8] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h0E, 6'h23, 6'h0D, 6'h08};
        logic [15:0] imms [8] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h8000, 16'hFFFC, 16'h7FFF, 16'h7FFF};
        logic [31:0] exps [8] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_8001, 32'h0000_FFFF,
                                  32'h0000_8000, 32'hFFFF_FFFC, 32'h0000_7FFF, 32'h0000_7FFF};
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            dif.instruction = enc(ops[i], 5'd3, 5'd4, imms[i]);
            #1;
            total++;
            if (dif.imme_extend !== exps[i])
                $display("FAIL extend_op%02h_imm%04h: got %h want %h", ops[i], imms[i], dif.imme_extend, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_priority();
        idle_inputs();
        reset = 1'b1;
        dif.instruction = enc(6'h08, 5'd0, 5'd9, 16'h0000);
        dif.reg_write   = 1'b1;
        dif.alu_result  = 32'h0000_0005;
        tick();
        reset = 1'b0;
        dif.reg_write = 1'b0;
        dif.dbg_addr  = 5'd9;
        #1;
        total++;
        if (dif.dbg_data !== 32'h0) $display("FAIL rst_prio_r9: got %h want %h", dif.dbg_data, 32'h0);
        else passed++;
        dif.dbg_addr = 5'd12;
        #1;
        total++;
        if (dif.dbg_data !== 32'h0) $display("FAIL rst_clears_r12: got %h want %h", dif.dbg_data, 32'h0);
        else passed++;
        dif.dbg_addr = 5'd31;
        #1;
        total++;
        if (dif.dbg_data !== 32'h0) $display("FAIL rst_clears_r31: got %h want %h", dif.dbg_data, 32'h0);
        else passed++;
        dif.reg_write  = 1'b1;
        dif.memto_reg  = 1'b1;
        dif.mem_data   = 32'hA5A5_0000;
        dif.alu_result = 32'h1111_1111;
        tick();
        dif.reg_write = 1'b0;
        dif.memto_reg = 1'b0;
        dif.dbg_addr  = 5'd9;
        #1;
        total++;
        if (dif.dbg_data !== 32'hA5A5_0000) $display("FAIL post_rst_mem_wb: got %h want %h", dif.dbg_data, 32'hA5A5_0000);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  dst  [3] = '{5'd3, 5'd4, 5'd29};
        logic [31:0] vals [3] = '{32'h3333_0003, 32'h4444_0004, 32'h0000_8000};
        idle_inputs();
        dif.reg_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dif.instruction = enc(6'h08, 5'd0, dst[i], 16'h0000);
            dif.alu_result  = vals[i];
            tick();
        end
        dif.reg_write = 1'b0;
        dif.instruction = enc(6'h00, 5'd3, 5'd4, 16'h0000);
        dif.dbg_addr = 5'd29;
        #1;
        total++;
        if (dif.read_data_1 !== vals[0]) $display("FAIL b2b_r3: got %h want %h", dif.read_data_1, vals[0]);
        else passed++;
        total++;
        if (dif.read_data_2 !== vals[1]) $display("FAIL b2b_r4: got %h want %h", dif.read_data_2, vals[1]);
        else passed++;
        total++;
        if (dif.dbg_data !== vals[2]) $display("FAIL b2b_r29: got %h want %h", dif.dbg_data, vals[2]);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_write_rt();
        test_zero_reg();
        test_rd_dest();
        test_jal();
        test_extend();
        test_reset_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
